ber_sync_checker: RTL and testbench
===================================

Name: ber_sync_checker

Overview:
Parametrised bit-error-rate checker for the PRBS loopback chain (prbs9 -> filterPolFas -> downSampler -> checker). It finds the delay between the local reference PRBS bit stream and the received hard-decision bit by windowed correlation over a configurable history depth. After lock it counts bits and errors, and it detects loss of lock and re-enters search automatically. Compared with the existing BER block it adds configurable lock and loss-of-lock thresholds, counter clear, saturation, and a state output.

Parameters:
NB_BER, 64, width of the bit and error counters
DELAY_DEPTH, 1024, reference history depth in valid samples; maximum searchable delay
NB_IDX, 10, width of the offset index; must satisfy 2**NB_IDX >= DELAY_DEPTH
SEARCH_LEN, 511, valid samples compared per candidate offset (one PRBS9 period)
LOCK_ERR_MAX, 0, maximum errors in a search window that still declares lock
LOL_WIN, 511, valid samples per loss-of-lock monitoring window
LOL_ERR_MAX, 64, a LOL window with more errors than this drops lock

Ports:
i_clock  in  1  system clock
i_reset  in  1  synchronous reset, active-high
i_enb  in  1  checker enable (switch)
i_valid  in  1  symbol strobe, one cycle per T
i_ref_bit  in  1  local reference PRBS bit
i_rx_bit  in  1  received bit (sign bit of the downsampled sample)
i_clear  in  1  synchronous clear of bit/error counters
o_state  out  2  0=IDLE, 1=SEARCH, 2=LOCKED
o_lock  out  1  high while LOCKED
o_led  out  1  equals o_lock
o_offset  out  NB_IDX  current candidate offset (SEARCH) or locked offset (LOCKED)
o_count_bit  out  NB_BER  bits compared while LOCKED
o_count_err  out  NB_BER  errors while LOCKED

Behaviour:
- One clock, i_clock. Reset is synchronous and active-high on i_reset. Reset has priority over every other input.
- Reset values: all outputs 0, history 0, state IDLE, window counters 0, candidate 0.
- The block acts only on cycles with i_valid=1 and i_enb=1 (a "sample").
- History: a DELAY_DEPTH-bit shift register loaded with i_ref_bit on each sample.
- Tap k is the reference bit from k+1 samples before the current sample; it is read from the history before the shift.
- A link delay of d samples locks at offset d-1.
- err = i_rx_bit XOR tap[candidate or offset].
- IDLE: go to SEARCH on the first cycle with i_enb=1. Candidate and window counters are 0 on entry.
- SEARCH: count samples and errors in the window. On the sample that completes SEARCH_LEN samples:
  - if the window errors, including the current sample, are <= LOCK_ERR_MAX: go to LOCKED and register o_offset=candidate;
  - otherwise: candidate+1, wrapping from DELAY_DEPTH-1 to 0, and clear the window.
  - o_lock rises on the cycle after that sample's clock edge.
- LOCKED:
  - Each sample increments o_count_bit; it increments o_count_err when err=1.
  - A LOL window of LOL_WIN samples counts errors. If the count at the window end exceeds LOL_ERR_MAX: go to SEARCH with candidate 0. o_lock falls the next cycle.
  - Counters hold their values on leaving LOCKED.
- Counters saturate at all-ones and never wrap.
- i_clear zeros both counters. When i_clear coincides with an increment, the result is 0; clear wins.
- i_enb=0 in any state: go to IDLE next cycle, lock drops, counters hold, history frozen. Re-enable restarts the search from candidate 0.
- Window counters are wide enough for SEARCH_LEN and LOL_WIN.
- Error accumulation during search saturates at LOCK_ERR_MAX+1.
- i_valid pulses on consecutive cycles are legal. Every pulse is a sample.

Test Plan:
1. Reset held high with i_enb=1 and toggling valids -> all outputs 0 and o_state=0. Release -> o_state=1 on the next cycle.
2. PRBS9 reference, rx = ref delayed 5 samples, no errors, one valid every 4 clocks -> candidates 0..3 fail. o_offset=4. o_lock rises one cycle after valid #2555. o_state=2.
3. After lock, invert every 100th rx bit for 10000 samples -> o_count_bit=10000, o_count_err=100, o_lock stays 1.
4. Change the link delay to 9 while locked -> o_lock falls at the end of the current LOL window. The search restarts at 0 and relocks with o_offset=8. Counters keep their pre-loss values.
5. With NB_BER=4, lock and run 20 samples -> o_count_bit saturates at 15. Pulse i_clear on a cycle with an error sample -> both counters read 0 next cycle.
6. Drop i_enb mid-search at candidate 3 -> o_state=0 and o_offset holds. Raise i_enb -> search restarts at candidate 0. Assert i_reset while locked -> all outputs 0 next cycle.

Source files
------------

// File: rtl/ber_sync_checker.sv
// BER checker: finds the reference-to-received delay by windowed correlation, then counts
// bits and errors while locked and falls back to search when the error rate climbs.
module ber_sync_checker #(
  parameter int unsigned NB_BER       = 64,
  parameter int unsigned DELAY_DEPTH  = 1024,
  parameter int unsigned NB_IDX       = 10,
  parameter int unsigned SEARCH_LEN   = 511,
  parameter int unsigned LOCK_ERR_MAX = 0,
  parameter int unsigned LOL_WIN      = 511,
  parameter int unsigned LOL_ERR_MAX  = 64
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_enb,
  input  logic              i_valid,
  input  logic              i_ref_bit,
  input  logic              i_rx_bit,
  input  logic              i_clear,
  output logic [1:0]        o_state,
  output logic              o_lock,
  output logic              o_led,
  output logic [NB_IDX-1:0] o_offset,
  output logic [NB_BER-1:0] o_count_bit,
  output logic [NB_BER-1:0] o_count_err
);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StSearch = 2'd1;
  localparam logic [1:0] StLocked = 2'd2;

  localparam int unsigned LEN_MAX = (SEARCH_LEN > LOL_WIN) ? SEARCH_LEN : LOL_WIN;
  localparam int unsigned ERR_MAX = (LOCK_ERR_MAX > LOL_ERR_MAX) ? LOCK_ERR_MAX : LOL_ERR_MAX;
  localparam int unsigned CNT_MAX = (LEN_MAX > ERR_MAX + 2) ? LEN_MAX : ERR_MAX + 2;
  localparam int unsigned NB_WIN  = $clog2(CNT_MAX + 1);
  localparam int unsigned NB_SUM  = NB_WIN + 1;

  localparam logic [NB_WIN-1:0] SEARCH_END  = NB_WIN'(SEARCH_LEN - 1);
  localparam logic [NB_WIN-1:0] LOL_END     = NB_WIN'(LOL_WIN - 1);
  localparam logic [NB_SUM-1:0] LOCK_LIM    = NB_SUM'(LOCK_ERR_MAX);
  localparam logic [NB_SUM-1:0] LOL_LIM     = NB_SUM'(LOL_ERR_MAX);
  localparam logic [NB_WIN-1:0] LOCK_CAP    = NB_WIN'(LOCK_ERR_MAX + 1);
  localparam logic [NB_WIN-1:0] LOL_CAP     = NB_WIN'(LOL_ERR_MAX + 1);
  localparam logic [NB_IDX-1:0] OFFSET_LAST = NB_IDX'(DELAY_DEPTH - 1);

  logic [1:0]             r_state;
  logic [DELAY_DEPTH-1:0] r_hist;
  logic [NB_IDX-1:0]      r_offset;
  logic [NB_WIN-1:0]      r_win;
  logic [NB_WIN-1:0]      r_err;
  logic [NB_BER-1:0]      r_count_bit;
  logic [NB_BER-1:0]      r_count_err;

  logic [1:0]        w_state_nxt;
  logic [NB_IDX-1:0] w_offset_nxt;
  logic [NB_WIN-1:0] w_win_nxt;
  logic [NB_WIN-1:0] w_err_nxt;
  logic [NB_BER-1:0] w_count_bit_nxt;
  logic [NB_BER-1:0] w_count_err_nxt;
  logic              w_sample;
  logic              w_err;
  logic [NB_SUM-1:0] w_err_sum;

  // Tap is read before the shift, so r_hist[k] is the reference from k+1 samples ago.
  assign w_sample  = i_valid & i_enb;
  assign w_err     = i_rx_bit ^ r_hist[r_offset];
  assign w_err_sum = NB_SUM'(r_err) + NB_SUM'(w_err);

  always_comb begin
    w_state_nxt     = r_state;
    w_offset_nxt    = r_offset;
    w_win_nxt       = r_win;
    w_err_nxt       = r_err;
    w_count_bit_nxt = r_count_bit;
    w_count_err_nxt = r_count_err;
    if (!i_enb) begin
      w_state_nxt = StIdle;
    end else begin
      case (r_state)
        StIdle: begin
          w_state_nxt  = StSearch;
          w_offset_nxt = '0;
          w_win_nxt    = '0;
          w_err_nxt    = '0;
        end
        StSearch: begin
          if (i_valid) begin
            if (r_win == SEARCH_END) begin
              w_win_nxt = '0;
              w_err_nxt = '0;
              if (w_err_sum <= LOCK_LIM) begin
                w_state_nxt = StLocked;
              end else if (r_offset == OFFSET_LAST) begin
                w_offset_nxt = '0;
              end else begin
                w_offset_nxt = r_offset + NB_IDX'(1);
              end
            end else begin
              w_win_nxt = r_win + NB_WIN'(1);
              w_err_nxt = (w_err_sum > LOCK_LIM) ? LOCK_CAP : w_err_sum[NB_WIN-1:0];
            end
          end
        end
        StLocked: begin
          if (i_valid) begin
            if (r_count_bit != '1) w_count_bit_nxt = r_count_bit + NB_BER'(1);
            if (w_err && (r_count_err != '1)) w_count_err_nxt = r_count_err + NB_BER'(1);
            if (r_win == LOL_END) begin
              w_win_nxt = '0;
              w_err_nxt = '0;
              if (w_err_sum > LOL_LIM) begin
                w_state_nxt  = StSearch;
                w_offset_nxt = '0;
              end
            end else begin
              w_win_nxt = r_win + NB_WIN'(1);
              w_err_nxt = (w_err_sum > LOL_LIM) ? LOL_CAP : w_err_sum[NB_WIN-1:0];
            end
          end
        end
        default: w_state_nxt = StIdle;
      endcase
    end
    if (i_clear) begin
      w_count_bit_nxt = '0;
      w_count_err_nxt = '0;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state     <= StIdle;
      r_hist      <= '0;
      r_offset    <= '0;
      r_win       <= '0;
      r_err       <= '0;
      r_count_bit <= '0;
      r_count_err <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_offset    <= w_offset_nxt;
      r_win       <= w_win_nxt;
      r_err       <= w_err_nxt;
      r_count_bit <= w_count_bit_nxt;
      r_count_err <= w_count_err_nxt;
      if (w_sample) r_hist <= {r_hist[DELAY_DEPTH-2:0], i_ref_bit};
    end
  end

  assign o_state     = r_state;
  assign o_lock      = (r_state == StLocked);
  assign o_led       = o_lock;
  assign o_offset    = r_offset;
  assign o_count_bit = r_count_bit;
  assign o_count_err = r_count_err;

endmodule

// File: tb/tb_ber_sync_checker.sv
// Directed bench for ber_sync_checker: a PRBS9 reference looped back through a programmable
// sample delay, checked on a 64-bit-counter instance and a 4-bit-counter instance.
module tb_ber_sync_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, enb, valid, ref_bit, rx_bit, clear;
  logic [1:0]  state, state4;
  logic        lock, lock4, led, led4;
  logic [9:0]  offset, offset4;
  logic [63:0] cbit, cerr;
  logic [3:0]  cbit4, cerr4;

  ber_sync_checker u_dut (
    .i_clock(clk), .i_reset(rst), .i_enb(enb), .i_valid(valid), .i_ref_bit(ref_bit),
    .i_rx_bit(rx_bit), .i_clear(clear), .o_state(state), .o_lock(lock), .o_led(led),
    .o_offset(offset), .o_count_bit(cbit), .o_count_err(cerr)
  );

  ber_sync_checker #(.NB_BER(4)) u_dut4 (
    .i_clock(clk), .i_reset(rst), .i_enb(enb), .i_valid(valid), .i_ref_bit(ref_bit),
    .i_rx_bit(rx_bit), .i_clear(clear), .o_state(state4), .o_lock(lock4), .o_led(led4),
    .o_offset(offset4), .o_count_bit(cbit4), .o_count_err(cerr4)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: PRBS9 stream and link delay in samples.
  logic [8:0] lfsr = 9'h1FF;
  bit         ref_arr[$];
  int         delay = 5;
  int         last_idx;
  bit         last_rx;

  task automatic sample(input bit inv);
    bit r;
    r        = lfsr[8];
    lfsr     = {lfsr[7:0], lfsr[8] ^ lfsr[4]};
    ref_arr.push_back(r);
    last_idx = ref_arr.size() - 1;
    last_rx  = ((last_idx >= delay) ? ref_arr[last_idx - delay] : 1'b0) ^ inv;
    ref_bit  = r;
    rx_bit   = last_rx;
    valid    = 1'b1;
    @(posedge clk); #1;
    valid    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, "_state"}, 64'(state), 64'd0);
    check_eq({tag, "_lock"}, 64'(lock), 64'd0);
    check_eq({tag, "_led"}, 64'(led), 64'd0);
    check_eq({tag, "_offset"}, 64'(offset), 64'd0);
    check_eq({tag, "_cbit"}, cbit, 64'd0);
    check_eq({tag, "_cerr"}, cerr, 64'd0);
    check_eq({tag, "_cbit4"}, 64'(cbit4), 64'd0);
    check_eq({tag, "_state4"}, 64'(state4), 64'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time exceeded, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  int  exp_err;
  bit  lock_dropped;

  initial begin
    rst = 1'b1; enb = 1'b1; valid = 1'b0; ref_bit = 1'b0; rx_bit = 1'b0; clear = 1'b0;

    // 1: reset with valids toggling
    for (int i = 0; i < 6; i++) begin
      valid = i[0]; ref_bit = 1'b1; rx_bit = i[1];
      @(posedge clk); #1;
    end
    valid = 1'b0;
    check_zero("rst");
    rst = 1'b0;
    idle(1);
    check_eq("rel_state", 64'(state), 64'd1);
    check_eq("rel_offset", 64'(offset), 64'd0);
    idle(1);

    // 2: delay 5, one valid per 4 clocks, lock at candidate 4 on sample 2555
    delay = 5;
    for (int i = 1; i <= 2555; i++) begin
      sample(1'b0);
      if (i == 2043) check_eq("srch_off3", 64'(offset), 64'd3);
      if (i == 2044) begin
        check_eq("srch_off4", 64'(offset), 64'd4);
        check_eq("srch_state", 64'(state), 64'd1);
      end
      if (i == 2554) check_eq("prelock", 64'(lock), 64'd0);
      idle(3);
    end
    check_eq("lock", 64'(lock), 64'd1);
    check_eq("led", 64'(led), 64'd1);
    check_eq("lock_state", 64'(state), 64'd2);
    check_eq("lock_offset", 64'(offset), 64'd4);
    check_eq("lock_cbit", cbit, 64'd0);
    check_eq("lock4", 64'(lock4), 64'd1);

    // 3: every 100th rx bit inverted, back-to-back valids
    lock_dropped = 1'b0;
    for (int k = 1; k <= 10000; k++) begin
      sample((k % 100) == 0);
      if (!lock) lock_dropped = 1'b1;
      if (k == 14) check_eq("sat4_14", 64'(cbit4), 64'd14);
      if (k == 20) check_eq("sat4_20", 64'(cbit4), 64'd15);
    end
    check_eq("run_lock_held", 64'(lock_dropped), 64'd0);
    check_eq("run_cbit", cbit, 64'd10000);
    check_eq("run_cerr", cerr, 64'd100);
    check_eq("run_cbit4", 64'(cbit4), 64'd15);
    check_eq("run_cerr4", 64'(cerr4), 64'd15);

    // 4: delay jumps to 9; 220 samples remain in the current LOL window
    delay   = 9;
    exp_err = 100;
    for (int k = 1; k <= 220; k++) begin
      sample(1'b0);
      exp_err += int'(last_rx ^ ref_arr[last_idx - 5]);
      if (k == 219) check_eq("lol_pre", 64'(lock), 64'd1);
    end
    check_eq("lol_lock", 64'(lock), 64'd0);
    check_eq("lol_state", 64'(state), 64'd1);
    check_eq("lol_offset", 64'(offset), 64'd0);
    check_eq("lol_cbit", cbit, 64'd10220);
    check_eq("lol_cerr", cerr, 64'(exp_err));
    for (int k = 1; k <= 4599; k++) begin
      sample(1'b0);
      if (k == 100) check_eq("hold_cbit", cbit, 64'd10220);
      if (k == 4598) check_eq("relock_pre", 64'(lock), 64'd0);
    end
    check_eq("relock", 64'(lock), 64'd1);
    check_eq("relock_offset", 64'(offset), 64'd8);
    check_eq("relock_cbit", cbit, 64'd10220);
    check_eq("relock_cerr", cerr, 64'(exp_err));

    // 5: counting resumes, then clear coinciding with an error sample
    for (int k = 0; k < 5; k++) sample(1'b0);
    check_eq("resume_cbit", cbit, 64'd10225);
    check_eq("resume_cbit4", 64'(cbit4), 64'd15);
    clear = 1'b1;
    sample(1'b1);
    clear = 1'b0;
    check_eq("clr_cbit", cbit, 64'd0);
    check_eq("clr_cerr", cerr, 64'd0);
    check_eq("clr_cbit4", 64'(cbit4), 64'd0);
    check_eq("clr_cerr4", 64'(cerr4), 64'd0);
    sample(1'b1);
    check_eq("post_clr_cbit", cbit, 64'd1);
    check_eq("post_clr_cerr", cerr, 64'd1);

    // 6: reset while locked, then drop enable mid-search at candidate 3
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check_zero("lrst");
    idle(1);
    for (int k = 0; k < 3 * 511 + 10; k++) sample(1'b0);
    check_eq("mid_offset", 64'(offset), 64'd3);
    enb = 1'b0;
    idle(1);
    check_eq("dis_state", 64'(state), 64'd0);
    check_eq("dis_offset", 64'(offset), 64'd3);
    check_eq("dis_lock", 64'(lock), 64'd0);
    valid = 1'b1; ref_bit = 1'b1; rx_bit = 1'b0;
    idle(1);
    valid = 1'b0;
    check_eq("dis_hold_state", 64'(state), 64'd0);
    enb = 1'b1;
    idle(1);
    check_eq("ren_state", 64'(state), 64'd1);
    check_eq("ren_offset", 64'(offset), 64'd0);
    for (int k = 1; k <= 9 * 511; k++) begin
      sample(1'b0);
      if (k == 9 * 511 - 1) check_eq("ren_prelock", 64'(lock), 64'd0);
    end
    check_eq("ren_lock", 64'(lock), 64'd1);
    check_eq("ren_lock_offset", 64'(offset), 64'd8);
    check_eq("ren_cbit", cbit, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
